npu_host_ctrl: RTL
==================

// Module: npu_host_ctrl
// PURPOSE
//  Host-bus front end and run sequencer for the NPU pipeline (conv1->conv2->fc1->fc2).
//  Decodes 15-bit host writes into image/weight buffer writes or control ops (rst/trigger/require/status).
//  Tracks load completeness, issues the pipeline start strobe, latches the result, and guards runs with a watchdog.
//  Sits between the external bus and the pipeline sequencer plus its operand buffers.
// PARAMETERS
//  IMG_SIZE     240    image bytes (16x15), region 3'b000
//  WC1_SIZE     90     conv1 weights (3x3x1x10), region 3'b001
//  WC2_SIZE     90     conv2 weights (3x3x10x1), region 3'b010
//  WFC1_SIZE    1320   fc1 weights (132x10), region 3'b011
//  WFC2_SIZE    10     fc2 weights, region 3'b100
//  RES_W        24     result width
//  TIMEOUT_CYC  65535  max RUN cycles before abort
// PORTS
//  clk           in   1      clock
//  rst           in   1      synchronous, active-high reset
//  bus_valid     in   1      host request valid (write-only bus; reads via require op)
//  bus_addr      in   15     [14:12] region, [11:0] offset/opcode
//  bus_wdata     in   8      signed write data
//  bus_ready     out  1      request accepted this cycle when bus_valid&bus_ready
//  bus_rvalid    out  1      one-cycle pulse: bus_rdata valid
//  bus_rdata     out  RES_W  require/status response
//  mem_we        out  1      buffer write strobe
//  mem_sel       out  3      target region (000..100)
//  mem_addr      out  12     buffer offset
//  mem_wdata     out  8      buffer data
//  npu_start     out  1      one-cycle pipeline start pulse
//  npu_soft_rst  out  1      one-cycle pipeline reset pulse
//  npu_done      in   1      pipeline completion pulse
//  npu_result    in   RES_W  pipeline result, valid with npu_done
//  busy          out  1      state==RUN
//  error         out  1      sticky error flag
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, loaded[4:0]=0, result_q=0, error=0, watchdog=0.
//  bus_ready=1 in IDLE/DONE; in RUN bus_ready=1 only for region 3'b101 (data writes stall).
//  Data write (region<=100), accepted: mem_we/sel/addr/wdata registered, visible next cycle (latency 1).
//   offset>=region size -> write dropped, error<=1. Write to offset size-1 sets loaded[region].
//   Region 110/111 -> dropped, error<=1.
//  Op writes (region 101), bus_wdata ignored:
//   12'd0 rst: npu_soft_rst pulse next cycle; state<=IDLE; loaded, error, watchdog cleared; result_q kept.
//   12'd1 trigger: in IDLE/DONE with loaded==5'b11111 -> npu_start pulse next cycle, state<=RUN, watchdog<=0.
//         loaded incomplete -> error<=1, no start. In RUN -> ignored (no error).
//   12'd2 require: next cycle bus_rvalid=1, bus_rdata=result_q.
//   12'd3 status: next cycle bus_rvalid=1, bus_rdata={..0, error, loaded[4:0], state[1:0]}.
//   other opcodes: error<=1.
//  FSM (state[1:0]): IDLE=0, RUN=1, DONE=2.
//   IDLE -trigger ok-> RUN. RUN -npu_done-> DONE, result_q<=npu_result.
//   RUN -watchdog==TIMEOUT_CYC-1-> IDLE, error<=1, npu_soft_rst pulse. DONE -trigger ok-> RUN.
//  loaded bits persist across runs (weights reused); only rst op / rst clear them.
//  Simultaneous in one cycle: rst op beats npu_done (result discarded) and timeout;
//   npu_done beats timeout (result latched, no error). npu_done outside RUN ignored.
//  rst mid-run: everything returns to reset values; no pulses issued.
// STRUCTURE
//  npu_pkg: region codes (REG_IMG..REG_OP), opcodes (OP_RST, OP_TRIG, OP_REQ, OP_STAT), state encodings.
//  Sub-module npu_addr_decode: combinational region/offset range check -> {is_data, is_op, in_range, is_last}.
//  Top: FSM, loaded register, watchdog counter, result latch, output registers.
// TESTING
//  Load all 5 regions to last offset, trigger -> npu_start 1 cycle later, busy=1; npu_done w/ 24'sd-1234 -> require returns FFFB2E.
//  Trigger with fc2 region not loaded -> no npu_start, error=1, status shows loaded=5'b01111, state=0.
//  Write addr 15'h00F0 (img offset 240) -> mem_we stays 0, error=1; offset 239 -> mem_we, loaded[0]=1.
//  RUN, no npu_done, TIMEOUT_CYC=16 -> state IDLE after 16 cycles, npu_soft_rst pulse, error=1.
//  During RUN, data write -> bus_ready=0 until DONE; rst op + npu_done same cycle -> IDLE, result_q unchanged.
//  Second trigger from DONE without reloading -> new run starts (loaded retained).

Source files
------------

// File: rtl/npu_pkg.sv
// Shared definitions for the NPU host controller slice.
// Contents: bus region codes, control opcodes, run-state encoding and
// the "all operand buffers loaded" mask.
package npu_pkg;

  localparam logic [2:0] REG_IMG  = 3'b000;
  localparam logic [2:0] REG_WC1  = 3'b001;
  localparam logic [2:0] REG_WC2  = 3'b010;
  localparam logic [2:0] REG_WFC1 = 3'b011;
  localparam logic [2:0] REG_WFC2 = 3'b100;
  localparam logic [2:0] REG_OP   = 3'b101;

  localparam logic [11:0] OP_RST  = 12'd0;
  localparam logic [11:0] OP_TRIG = 12'd1;
  localparam logic [11:0] OP_REQ  = 12'd2;
  localparam logic [11:0] OP_STAT = 12'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [4:0] LOADED_ALL = 5'b11111;

endpackage

// File: rtl/npu_addr_decode.sv
// Combinational host address classifier.
// Ports:
//   addr     in  15  [14:12] region, [11:0] offset/opcode
//   is_data  out 1   region targets an operand buffer (000..100)
//   is_op    out 1   region is the control-op space (101)
//   in_range out 1   data offset lies inside its buffer
//   is_last  out 1   data offset is the final byte of its buffer
module npu_addr_decode
  import npu_pkg::*;
#(
  parameter int IMG_SIZE  = 240,
  parameter int WC1_SIZE  = 90,
  parameter int WC2_SIZE  = 90,
  parameter int WFC1_SIZE = 1320,
  parameter int WFC2_SIZE = 10
) (
  input  logic [14:0] addr,
  output logic        is_data,
  output logic        is_op,
  output logic        in_range,
  output logic        is_last
);

  logic [2:0]  region;
  logic [11:0] offset;
  logic [11:0] size;

  assign region = addr[14:12];
  assign offset = addr[11:0];

  always_comb begin
    size = 12'd0;
    case (region)
      REG_IMG:  size = 12'(IMG_SIZE);
      REG_WC1:  size = 12'(WC1_SIZE);
      REG_WC2:  size = 12'(WC2_SIZE);
      REG_WFC1: size = 12'(WFC1_SIZE);
      REG_WFC2: size = 12'(WFC2_SIZE);
      default:  size = 12'd0;
    endcase
  end

  assign is_data  = (region <= REG_WFC2);
  assign is_op    = (region == REG_OP);
  assign in_range = is_data && (offset < size);
  assign is_last  = is_data && (offset == size - 12'd1);

endmodule

// File: rtl/npu_host_ctrl.sv
// Host-bus front end and run sequencer for the conv1->conv2->fc1->fc2 NPU.
// Decodes host writes into operand-buffer writes or control ops, tracks which
// buffers have been fully loaded, starts runs, latches the result and aborts
// runs that exceed the watchdog limit.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   bus_valid/addr/wdata      host write request (write-only bus)
//   bus_ready                 request accepted when bus_valid & bus_ready
//   bus_rvalid/bus_rdata      one-cycle response to require/status ops
//   mem_we/sel/addr/wdata     operand buffer write port (registered)
//   npu_start, npu_soft_rst   one-cycle pipeline control pulses
//   npu_done, npu_result      pipeline completion and its result
//   busy, error               run in progress, sticky error flag
module npu_host_ctrl
  import npu_pkg::*;
#(
  parameter int IMG_SIZE    = 240,
  parameter int WC1_SIZE    = 90,
  parameter int WC2_SIZE    = 90,
  parameter int WFC1_SIZE   = 1320,
  parameter int WFC2_SIZE   = 10,
  parameter int RES_W       = 24,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bus_valid,
  input  logic [14:0]             bus_addr,
  input  logic signed [7:0]       bus_wdata,
  output logic                    bus_ready,
  output logic                    bus_rvalid,
  output logic [RES_W-1:0]        bus_rdata,
  output logic                    mem_we,
  output logic [2:0]              mem_sel,
  output logic [11:0]             mem_addr,
  output logic signed [7:0]       mem_wdata,
  output logic                    npu_start,
  output logic                    npu_soft_rst,
  input  logic                    npu_done,
  input  logic signed [RES_W-1:0] npu_result,
  output logic                    busy,
  output logic                    error
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic is_data, is_op, in_range, is_last, accept;

  npu_addr_decode #(
    .IMG_SIZE (IMG_SIZE),
    .WC1_SIZE (WC1_SIZE),
    .WC2_SIZE (WC2_SIZE),
    .WFC1_SIZE(WFC1_SIZE),
    .WFC2_SIZE(WFC2_SIZE)
  ) u_dec (
    .addr    (bus_addr),
    .is_data (is_data),
    .is_op   (is_op),
    .in_range(in_range),
    .is_last (is_last)
  );

  state_e                    state_q, state_d;
  logic [4:0]                loaded_q, loaded_d;
  logic [WD_W-1:0]           wd_q, wd_d;
  logic signed [RES_W-1:0]   result_q, result_d;
  logic                      error_q, error_d;
  logic                      rvalid_q, rvalid_d;
  logic [RES_W-1:0]          rdata_q, rdata_d;
  logic                      mem_we_q, mem_we_d;
  logic [2:0]                mem_sel_q, mem_sel_d;
  logic [11:0]               mem_addr_q, mem_addr_d;
  logic signed [7:0]         mem_wdata_q, mem_wdata_d;
  logic                      start_q, start_d;
  logic                      soft_rst_q, soft_rst_d;

  // Data writes stall while a run is active; control ops are always taken.
  assign bus_ready = !rst && ((state_q != ST_RUN) || is_op);
  assign accept    = bus_valid && bus_ready;

  always_comb begin
    state_d     = state_q;
    loaded_d    = loaded_q;
    wd_d        = wd_q;
    result_d    = result_q;
    error_d     = error_q;
    rvalid_d    = 1'b0;
    rdata_d     = rdata_q;
    mem_we_d    = 1'b0;
    mem_sel_d   = mem_sel_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    start_d     = 1'b0;
    soft_rst_d  = 1'b0;

    // Run supervision: completion takes priority over the watchdog.
    if (state_q == ST_RUN) begin
      if (npu_done) begin
        state_d  = ST_DONE;
        result_d = npu_result;
      end else if (wd_q == WD_LAST) begin
        state_d    = ST_IDLE;
        error_d    = 1'b1;
        soft_rst_d = 1'b1;
        wd_d       = '0;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end

    // Host request handling comes last so a rst op overrides the run
    // supervision outcome above (including discarding a same-cycle result).
    if (accept) begin
      if (is_data) begin
        if (in_range) begin
          mem_we_d    = 1'b1;
          mem_sel_d   = bus_addr[14:12];
          mem_addr_d  = bus_addr[11:0];
          mem_wdata_d = bus_wdata;
          if (is_last) loaded_d = loaded_q | (5'b00001 << bus_addr[14:12]);
        end else begin
          error_d = 1'b1;
        end
      end else if (is_op) begin
        case (bus_addr[11:0])
          OP_RST: begin
            soft_rst_d = 1'b1;
            state_d    = ST_IDLE;
            loaded_d   = '0;
            error_d    = 1'b0;
            wd_d       = '0;
            result_d   = result_q;
          end
          OP_TRIG: begin
            if (state_q != ST_RUN) begin
              if (loaded_q == LOADED_ALL) begin
                start_d = 1'b1;
                state_d = ST_RUN;
                wd_d    = '0;
              end else begin
                error_d = 1'b1;
              end
            end
          end
          OP_REQ: begin
            rvalid_d = 1'b1;
            rdata_d  = result_q;
          end
          OP_STAT: begin
            rvalid_d = 1'b1;
            rdata_d  = RES_W'({error_q, loaded_q, state_q});
          end
          default: error_d = 1'b1;
        endcase
      end else begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      loaded_q    <= '0;
      wd_q        <= '0;
      result_q    <= '0;
      error_q     <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_sel_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      start_q     <= 1'b0;
      soft_rst_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      loaded_q    <= loaded_d;
      wd_q        <= wd_d;
      result_q    <= result_d;
      error_q     <= error_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      mem_we_q    <= mem_we_d;
      mem_sel_q   <= mem_sel_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      start_q     <= start_d;
      soft_rst_q  <= soft_rst_d;
    end
  end

  assign bus_rvalid   = rvalid_q;
  assign bus_rdata    = rdata_q;
  assign mem_we       = mem_we_q;
  assign mem_sel      = mem_sel_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign npu_start    = start_q;
  assign npu_soft_rst = soft_rst_q;
  assign busy         = (state_q == ST_RUN);
  assign error        = error_q;

endmodule
